// File: rtl/iir_decim_reader.sv
// Boxcar decimator + FIFO reader for the IIR sample stream.
// Define DECIM_ROUND_EN for round-half-up averaging instead of floor.
module iir_decim_reader #(
  parameter int DECIM_LOG2      = 3,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_valid,
  input  logic signed [15:0]         s_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic signed [15:0]         m_data,
  output logic [FIFO_DEPTH_LOG2:0]   fifo_level,
  output logic                       overflow,
  input  logic                       clr_ovf
);

  localparam int N  = 1 << DECIM_LOG2;
  localparam int D  = 1 << FIFO_DEPTH_LOG2;
  localparam int AW = 16 + DECIM_LOG2;
  localparam int CW = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
  localparam int PW = FIFO_DEPTH_LOG2;
  localparam int LW = FIFO_DEPTH_LOG2 + 1;

  logic signed [AW-1:0] r_acc;
  logic [CW-1:0]        r_cnt;
  logic [15:0]          r_mem [D];
  logic [PW-1:0]        r_wptr;
  logic [PW-1:0]        r_rptr;
  logic [LW-1:0]        r_level;
  logic                 r_ovf;

  logic                 w_last;
  logic signed [AW:0]   w_sum;
  logic signed [AW:0]   w_rnd;
  logic signed [15:0]   w_res;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_acc;
  logic                 w_drop;

  assign w_last = (r_cnt == CW'(N - 1));
  assign w_sum  = {r_acc[AW-1], r_acc}
                + {{(AW - 15){s_data[15]}}, s_data};

`ifdef DECIM_ROUND_EN
  // Half-LSB offset; collapses to 0 when N = 1.
  assign w_rnd = w_sum + (AW + 1)'((1 << DECIM_LOG2) >> 1);
`else
  assign w_rnd = w_sum;
`endif

  assign w_res = 16'(w_rnd >>> DECIM_LOG2);

  assign w_full  = (r_level == LW'(D));
  assign w_empty = (r_level == '0);
  assign w_pop   = !w_empty && m_ready;
  assign w_push  = s_valid && w_last;
  assign w_acc   = w_push && (!w_full || w_pop);
  assign w_drop  = w_push && w_full && !w_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (s_valid) begin
      if (w_last) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else begin
        r_acc <= w_sum[AW-1:0];
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_acc) r_mem[r_wptr] <= w_res;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_acc) r_wptr <= r_wptr + PW'(1);
      if (w_pop) r_rptr <= r_rptr + PW'(1);
      unique case ({w_acc, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // A fresh drop outranks a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_ovf <= 1'b0;
    else if (w_drop)  r_ovf <= 1'b1;
    else if (clr_ovf) r_ovf <= 1'b0;
  end

  assign m_valid    = !w_empty;
  assign m_data     = w_empty ? '0 : r_mem[r_rptr];
  assign fifo_level = r_level;
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_iir_decim_reader.sv
// Scoreboard bench for iir_decim_reader (default parameters).
// Expected values come from a queue-based model of group averaging.
module tb_iir_decim_reader;

  localparam int N = 8;
  localparam int D = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              s_valid = 1'b0;
  logic signed [15:0] s_data = '0;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic signed [15:0] m_data;
  logic [4:0]        fifo_level;
  logic              overflow;
  logic              clr_ovf = 1'b0;

  iir_decim_reader #(.DECIM_LOG2(3), .FIFO_DEPTH_LOG2(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .fifo_level(fifo_level), .overflow(overflow), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nerr = 0;
  bit in_rst = 1'b1;
  int grp[$];
  int mq[$];
  int expq[$];
  bit movf = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Average of a group of N samples, floor or round-half-up.
  function automatic int avg(input int sum);
    int s;
    int q;
    s = sum;
`ifdef DECIM_ROUND_EN
    s = s + N / 2;
`endif
    q = s / N;
    if ((s % N) != 0 && s < 0) q = q - 1;
    return q;
  endfunction

  task automatic model_step();
    bit pop;
    bit push;
    int val;
    int sum;
    int sz0;
    pop  = (mq.size() > 0) && m_ready;
    push = 1'b0;
    val  = 0;
    if (s_valid) begin
      grp.push_back(int'(s_data));
      if (grp.size() == N) begin
        sum = 0;
        foreach (grp[i]) sum += grp[i];
        val  = avg(sum);
        push = 1'b1;
        grp.delete();
      end
    end
    sz0 = mq.size();
    if (pop) void'(mq.pop_front());
    if (push && (sz0 < D || pop)) begin
      mq.push_back(val);
      expq.push_back(val);
    end else if (push) begin
      movf = 1'b1;
    end else if (clr_ovf) begin
      movf = 1'b0;
    end
    if (push && !(sz0 < D || pop)) movf = 1'b1;
    else if (!(push && sz0 >= D && !pop) && clr_ovf) movf = 1'b0;
  endtask

  task automatic cyc(input bit v, input int d, input bit r, input bit c);
    s_valid = v;
    s_data  = 16'(d);
    m_ready = r;
    clr_ovf = c;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic group(input int d, input bit r);
    for (int i = 0; i < N; i++) cyc(1'b1, d, r, 1'b0);
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) cyc(1'b0, 0, r, 1'b0);
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!in_rst) begin
        chk("level", int'(fifo_level), mq.size());
        chk("overflow", int'(overflow), int'(movf));
        chk("m_valid", int'(m_valid), int'(mq.size() > 0));
        if (!m_valid) chk("m_data_empty", int'(m_data), 0);
        if (m_valid && m_ready) begin
          if (expq.size() == 0) chk("unexpected_pop", 1, 0);
          else chk("m_data", int'(m_data), expq.pop_front());
        end
      end
    end
  end

  initial begin : stim
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", int'(m_valid), 0);
    chk("rst_level", int'(fifo_level), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    in_rst = 1'b0;

    group(1000, 1'b1);
    idle(3, 1'b1);
    for (int i = 0; i < 7; i++) cyc(1'b1, 0, 1'b1, 1'b0);
    cyc(1'b1, 4, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) cyc(1'b1, 0, 1'b1, 1'b0);
    cyc(1'b1, -4, 1'b1, 1'b0);
    idle(2, 1'b1);
    for (int i = 0; i < N; i++) begin
      cyc(1'b1, -32768, 1'b1, 1'b0);
      idle($urandom_range(0, 2), 1'b1);
    end
    for (int i = 0; i < N; i++) begin
      cyc(1'b1, 32767, 1'b1, 1'b0);
      idle($urandom_range(0, 2), 1'b1);
    end
    idle(2, 1'b1);

    for (int g = 1; g <= 17; g++) group(g, 1'b0);
    chk("ovf_level", int'(fifo_level), 16);
    chk("ovf_flag", int'(overflow), 1);
    idle(16, 1'b1);
    cyc(1'b0, 0, 1'b1, 1'b1);
    chk("ovf_clr", int'(overflow), 0);

    for (int g = 1; g <= 16; g++) group(100 + g, 1'b0);
    for (int i = 0; i < N - 1; i++) cyc(1'b1, 555, 1'b0, 1'b0);
    cyc(1'b1, 555, 1'b1, 1'b0);
    chk("full_pp_level", int'(fifo_level), 16);
    chk("full_pp_ovf", int'(overflow), 0);
    idle(18, 1'b1);

    group(300, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 500, 1'b0, 1'b0);
    s_valid = 1'b0;
    in_rst = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", int'(m_valid), 0);
    chk("mrst_data", int'(m_data), 0);
    chk("mrst_level", int'(fifo_level), 0);
    chk("mrst_ovf", int'(overflow), 0);
    grp.delete();
    mq.delete();
    expq.delete();
    movf = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    in_rst = 1'b0;
    group(200, 1'b1);
    idle(2, 1'b1);

    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 9) < 7, int'($urandom_range(0, 65535)) - 32768,
          $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
    idle(40, 1'b1);
    chk("drained", expq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
